// File: rtl/mac_stop_pkg.sv
// Shared types and default sizing for the stoppable matrix-multiply engine.
package mac_stop_pkg;

    localparam int unsigned M_DEF  = 4;
    localparam int unsigned K_DEF  = 4;
    localparam int unsigned N_DEF  = 4;
    localparam int unsigned DW_DEF = 32;
    localparam int unsigned RW_DEF = 2 * DW_DEF + $clog2(K_DEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC   = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ABORT = 3'd4
    } state_t;

    // Index width for a dimension, kept at least one bit wide for size-1 dimensions.
    function automatic int unsigned addr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned MW_DEF = addr_w(M_DEF);
    localparam int unsigned KW_DEF = addr_w(K_DEF);
    localparam int unsigned NW_DEF = addr_w(N_DEF);

endpackage

// File: rtl/mac_stop_acc.sv
// Unsigned multiply-accumulate register with synchronous clear.
module mac_stop_acc #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 66
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [RW-1:0] acc
);

    localparam int unsigned PW = 2 * DW;

    logic [PW-1:0] prod;

    assign prod = PW'(a) * PW'(b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + RW'(prod);
        end
    end

endmodule

// File: rtl/mac_stop_seq.sv
// Sequencer that walks C = A x B element by element, with start/stop control.
module mac_stop_seq
    import mac_stop_pkg::*;
#(
    parameter int unsigned M                        = M_DEF,
    parameter int unsigned K                        = K_DEF,
    parameter int unsigned N                        = N_DEF,
    parameter int unsigned DATA_WIDTH_INIT_MATRIX   = DW_DEF,
    parameter int unsigned DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                stop,
    output logic                                matrix_a_re,
    output logic [addr_w(M)-1:0]                row_addr_a,
    output logic [addr_w(K)-1:0]                col_addr_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
    output logic                                matrix_b_re,
    output logic [addr_w(K)-1:0]                row_addr_b,
    output logic [addr_w(N)-1:0]                col_addr_b,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b,
    output logic                                matrix_c_we,
    output logic [addr_w(M)-1:0]                row_addr_c,
    output logic [addr_w(N)-1:0]                col_addr_c,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
    output logic                                busy,
    output logic                                done,
    output logic                                stopped
);

    localparam int unsigned MW = addr_w(M);
    localparam int unsigned KW = addr_w(K);
    localparam int unsigned NW = addr_w(N);

    state_t        state;
    logic [MW-1:0] i;
    logic [KW-1:0] k;
    logic [NW-1:0] j;

    logic          k_last;
    logic          j_last;
    logic          elem_last;
    logic [KW-1:0] k_inc;
    logic [MW-1:0] i_nxt;
    logic [NW-1:0] j_nxt;
    logic          acc_clr;
    logic          acc_en;

    // Counter stepping helpers shared by the MAC and WRITE transitions.
    always_comb begin
        k_last    = (k == KW'(K - 1));
        j_last    = (j == NW'(N - 1));
        elem_last = j_last && (i == MW'(M - 1));
        k_inc     = KW'(k + 1'b1);
        j_nxt     = j_last ? '0 : NW'(j + 1'b1);
        i_nxt     = i;
        if (j_last) begin
            i_nxt = (i == MW'(M - 1)) ? '0 : MW'(i + 1'b1);
        end
        acc_clr   = ((state == IDLE) && start) || (state == WRITE) || (state == ABORT);
        acc_en    = (state == MAC);
    end

    // Outputs are registered alongside the state so they line up with it cycle for cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            matrix_a_re <= 1'b0;
            matrix_b_re <= 1'b0;
            matrix_c_we <= 1'b0;
            row_addr_a  <= '0;
            col_addr_a  <= '0;
            row_addr_b  <= '0;
            col_addr_b  <= '0;
            row_addr_c  <= '0;
            col_addr_c  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stopped     <= 1'b0;
        end else begin
            matrix_a_re <= 1'b0;
            matrix_b_re <= 1'b0;
            matrix_c_we <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            stopped     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= MAC;
                        i           <= '0;
                        j           <= '0;
                        k           <= '0;
                        matrix_a_re <= 1'b1;
                        matrix_b_re <= 1'b1;
                        busy        <= 1'b1;
                        row_addr_a  <= '0;
                        col_addr_a  <= '0;
                        row_addr_b  <= '0;
                        col_addr_b  <= '0;
                    end
                end
                MAC: begin
                    if (stop) begin
                        state   <= ABORT;
                        stopped <= 1'b1;
                    end else if (k_last) begin
                        state       <= WRITE;
                        k           <= '0;
                        matrix_c_we <= 1'b1;
                        busy        <= 1'b1;
                        row_addr_c  <= i;
                        col_addr_c  <= j;
                    end else begin
                        k           <= k_inc;
                        matrix_a_re <= 1'b1;
                        matrix_b_re <= 1'b1;
                        busy        <= 1'b1;
                        col_addr_a  <= k_inc;
                        row_addr_b  <= k_inc;
                    end
                end
                WRITE: begin
                    i <= i_nxt;
                    j <= j_nxt;
                    if (stop) begin
                        state   <= ABORT;
                        stopped <= 1'b1;
                    end else if (elem_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state       <= MAC;
                        matrix_a_re <= 1'b1;
                        matrix_b_re <= 1'b1;
                        busy        <= 1'b1;
                        row_addr_a  <= i_nxt;
                        col_addr_a  <= '0;
                        row_addr_b  <= '0;
                        col_addr_b  <= j_nxt;
                    end
                end
                DONE: begin
                    if (stop) begin
                        state   <= ABORT;
                        stopped <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ABORT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mac_stop_acc #(
        .DW (DATA_WIDTH_INIT_MATRIX),
        .RW (DATA_WIDTH_RESULT_MATRIX)
    ) u_acc (
        .clk   (clk),
        .reset (reset),
        .clr   (acc_clr),
        .en    (acc_en),
        .a     (data_out_a),
        .b     (data_out_b),
        .acc   (data_in_c)
    );

endmodule

// File: tb/tb_mac_stop_seq.sv
// Scoreboarded bench: behavioural matrix model predicts C writes, monitor checks them.
module tb_mac_stop_seq;

    localparam int unsigned M  = 4;
    localparam int unsigned K  = 4;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 2 * DW + $clog2(K);

    logic          clk;
    logic          reset;
    logic          start;
    logic          stop;
    logic          matrix_a_re;
    logic [1:0]    row_addr_a;
    logic [1:0]    col_addr_a;
    logic [DW-1:0] data_out_a;
    logic          matrix_b_re;
    logic [1:0]    row_addr_b;
    logic [1:0]    col_addr_b;
    logic [DW-1:0] data_out_b;
    logic          matrix_c_we;
    logic [1:0]    row_addr_c;
    logic [1:0]    col_addr_c;
    logic [RW-1:0] data_in_c;
    logic          busy;
    logic          done;
    logic          stopped;

    typedef struct {
        int          i;
        int          j;
        logic [RW-1:0] v;
    } wr_t;

    wr_t sb[$];

    logic [DW-1:0] mem_a [M][K];
    logic [DW-1:0] mem_b [K][N];
    logic [RW-1:0] mem_c [M][N];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int stop_cnt = 0;
    int wr_cnt   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mac_stop_seq #(
        .M (M), .K (K), .N (N),
        .DATA_WIDTH_INIT_MATRIX   (DW),
        .DATA_WIDTH_RESULT_MATRIX (RW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .matrix_a_re (matrix_a_re),
        .row_addr_a  (row_addr_a),
        .col_addr_a  (col_addr_a),
        .data_out_a  (data_out_a),
        .matrix_b_re (matrix_b_re),
        .row_addr_b  (row_addr_b),
        .col_addr_b  (col_addr_b),
        .data_out_b  (data_out_b),
        .matrix_c_we (matrix_c_we),
        .row_addr_c  (row_addr_c),
        .col_addr_c  (col_addr_c),
        .data_in_c   (data_in_c),
        .busy        (busy),
        .done        (done),
        .stopped     (stopped)
    );

    assign data_out_a = mem_a[row_addr_a][col_addr_a];
    assign data_out_b = mem_b[row_addr_b][col_addr_b];

    always @(posedge clk) begin
        if (matrix_c_we) mem_c[row_addr_c][col_addr_c] <= data_in_c;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every C write must match the head of the expected-write queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (done)    done_cnt++;
            if (stopped) stop_cnt++;
            if (matrix_c_we) begin
                wr_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr (%0d,%0d) expected no write", row_addr_c, col_addr_c);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check("c_row", 128'(row_addr_c), 128'(e.i));
                    check("c_col", 128'(col_addr_c), 128'(e.j));
                    check("c_data", 128'(data_in_c), 128'(e.v));
                end
            end
        end
    end

    task automatic load(input int unsigned av[16], input int unsigned bv[16]);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mem_a[r][c] = av[r*4+c];
                mem_b[r][c] = bv[r*4+c];
            end
    endtask

    task automatic load_random();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                mem_a[r][c] = $urandom;
                mem_b[r][c] = $urandom;
            end
    endtask

    task automatic fill_c(input logic [RW-1:0] v);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < N; c++) mem_c[r][c] = v;
    endtask

    // Reference: plain row-major dot products; the first n elements are expected to be written.
    task automatic expect_elems(input int n);
        for (int e = 0; e < n; e++) begin
            wr_t w;
            w.i = e / N;
            w.j = e % N;
            w.v = '0;
            for (int kk = 0; kk < K; kk++) w.v += RW'(mem_a[w.i][kk]) * RW'(mem_b[kk][w.j]);
            sb.push_back(w);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_ctl"}, 128'({matrix_a_re, matrix_b_re, matrix_c_we, busy, done, stopped}), 128'(0));
        check({name, "_addr"}, 128'({row_addr_a, col_addr_a, row_addr_b, col_addr_b, row_addr_c, col_addr_c}), 128'(0));
        check({name, "_data"}, 128'(data_in_c), 128'(0));
    endtask

    task automatic run(input int restart_at, input int stop_at, output int done_cyc, output int busy_cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        done_cyc = 0;
        busy_cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            start = (c == restart_at);
            stop  = (c == stop_at);
            if (busy) busy_cyc++;
            if (done && done_cyc == 0) done_cyc = c;
            if (done_cyc != 0 && c >= done_cyc + 3) break;
            if (stop_at != 0 && c >= stop_at + 6) break;
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic full_run(input string name, input int restart_at);
        int dc, bc, d0, w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        expect_elems(M * N);
        run(restart_at, 0, dc, bc);
        check({name, "_done_cycle"}, 128'(dc), 128'(81));
        check({name, "_busy_cycles"}, 128'(bc), 128'(80));
        check({name, "_done_pulses"}, 128'(done_cnt - d0), 128'(1));
        check({name, "_writes"}, 128'(wr_cnt - w0), 128'(16));
        check({name, "_sb_empty"}, 128'(sb.size()), 128'(0));
        check({name, "_busy_after"}, 128'(busy), 128'(0));
    endtask

    initial begin
        logic [RW-1:0] all_ones_c;
        int exp1 [16];
        int dc, bc, d0, s0, w0;

        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        fill_c('0);
        load('{default: 0}, '{default: 0});
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_zero("idle_after_reset");

        // Test plan matrix 1
        load('{4,3,2,5, 3,4,5,2, 5,2,4,3, 2,5,3,4}, '{7,6,5,8, 6,7,8,5, 8,5,7,6, 5,8,6,7});
        full_run("plan1", 0);
        exp1 = '{87,95,88,94, 95,87,94,88, 94,88,87,95, 88,94,95,87};
        for (int e = 0; e < 16; e++) check("plan1_c", 128'(mem_c[e/4][e%4]), 128'(exp1[e]));

        // Test plan matrix 2
        load('{6,2,5,2, 6,2,6,1, 2,4,5,2, 7,2,5,1}, '{1,1,4,4, 1,7,2,1, 3,2,1,1, 2,1,6,6});
        full_run("plan2", 0);
        check("plan2_c00", 128'(mem_c[0][0]), 128'(27));
        check("plan2_c01", 128'(mem_c[0][1]), 128'(32));
        check("plan2_c02", 128'(mem_c[0][2]), 128'(45));
        check("plan2_c03", 128'(mem_c[0][3]), 128'(43));
        check("plan2_c30", 128'(mem_c[3][0]), 128'(26));
        check("plan2_c31", 128'(mem_c[3][1]), 128'(32));
        check("plan2_c32", 128'(mem_c[3][2]), 128'(43));
        check("plan2_c33", 128'(mem_c[3][3]), 128'(41));

        // All-ones operands, with a start pulse landing mid-run
        load('{default: 32'hFFFF_FFFF}, '{default: 32'hFFFF_FFFF});
        full_run("maxval_restart", 30);
        all_ones_c = 66'h3_FFFF_FFF8_0000_0004;
        for (int e = 0; e < 16; e++) check("maxval_c", 128'(mem_c[e/4][e%4]), 128'(all_ones_c));

        // Stop in the 3rd MAC cycle of element (1,2): cycle 6*(K+1)+3
        load('{4,3,2,5, 3,4,5,2, 5,2,4,3, 2,5,3,4}, '{7,6,5,8, 6,7,8,5, 8,5,7,6, 5,8,6,7});
        fill_c(66'h5A5A);
        d0 = done_cnt; s0 = stop_cnt; w0 = wr_cnt;
        expect_elems(6);
        run(0, 33, dc, bc);
        check("stop_done_cycle", 128'(dc), 128'(0));
        check("stop_pulses", 128'(stop_cnt - s0), 128'(1));
        check("stop_done_pulses", 128'(done_cnt - d0), 128'(0));
        check("stop_writes", 128'(wr_cnt - w0), 128'(6));
        check("stop_sb_empty", 128'(sb.size()), 128'(0));
        check("stop_busy_after", 128'(busy), 128'(0));
        check("stop_c11", 128'(mem_c[1][1]), 128'(87));
        for (int e = 6; e < 16; e++) check("stop_c_untouched", 128'(mem_c[e/4][e%4]), 128'(66'h5A5A));

        // Reset in the middle of a run, then a clean random run
        load_random();
        expect_elems(M * N);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (22) @(negedge clk);
        reset = 1'b1;
        #1 check_zero("mid_reset");
        sb.delete();
        @(negedge clk);
        check_zero("mid_reset_hold");
        reset = 1'b0;
        @(negedge clk);
        full_run("after_reset", 0);

        for (int t = 0; t < 3; t++) begin
            load_random();
            full_run("random", 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
